// File: rtl/lock_pkg.sv
// Shared types and default constants for the electronic-lock front end.
// The FSM state type is also used by the debug port of button_conditioner_if.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        CONFLICT = 2'd2
    } lock_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF  = 1000;

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw key inputs and the conditioned strobes.
// master: the conditioner; slave: the key source and strobe consumer.
interface button_conditioner_if;
    import lock_pkg::*;

    // No valid/ready here: b0/b1/seq_clear are self-timed one-cycle strobes
    // that the consumer must take in the cycle they are high.
    logic        btn0_raw;
    logic        btn1_raw;
    logic        b0;
    logic        b1;
    logic        conflict;
    logic        seq_clear;
    lock_state_e state_dbg;

    modport master (
        input  btn0_raw,
        input  btn1_raw,
        output b0,
        output b1,
        output conflict,
        output seq_clear,
        output state_dbg
    );

    modport slave (
        output btn0_raw,
        output btn1_raw,
        input  b0,
        input  b1,
        input  conflict,
        input  seq_clear,
        input  state_dbg
    );

endinterface

// File: rtl/btn_debounce.sv
// Synchroniser chain plus debounce counter for one raw push-button.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   sync_bit;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_bit != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Turns two bouncy keys into single-cycle, mutually exclusive b0/b1 strobes.
// Optional entry timeout (seq_clear) is built only when BUTTON_TIMEOUT_EN is defined.
module button_conditioner
    import lock_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.master bus
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: parameter out of range");
    end

    logic lvl0;
    logic lvl1;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb0 (
        .clk  (clk),
        .reset(reset),
        .raw  (bus.btn0_raw),
        .level(lvl0)
    );

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb1 (
        .clk  (clk),
        .reset(reset),
        .raw  (bus.btn1_raw),
        .level(lvl1)
    );

    lock_state_e state_q;
    lock_state_e state_d;
    logic        held1_q;
    logic        held1_d;
    logic        b0_q;
    logic        b0_d;
    logic        b1_q;
    logic        b1_d;
    logic        conflict_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            held1_q <= 1'b0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            held1_q <= held1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    // held1_q remembers which key owns HELD so a hand-over to the other key is a conflict.
    always_comb begin
        state_d = state_q;
        held1_d = held1_q;
        case (state_q)
            IDLE: begin
                if (lvl0 && lvl1) begin
                    state_d = CONFLICT;
                end else if (lvl0 || lvl1) begin
                    state_d = HELD;
                    held1_d = lvl1;
                end
            end
            HELD: begin
                if (held1_q ? lvl0 : lvl1) begin
                    state_d = CONFLICT;
                end else if (!lvl0 && !lvl1) begin
                    state_d = IDLE;
                end
            end
            CONFLICT: begin
                if (!lvl0 && !lvl1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        b0_d       = 1'b0;
        b1_d       = 1'b0;
        conflict_c = 1'b0;
        case (state_q)
            IDLE: begin
                b0_d = lvl0 & ~lvl1;
                b1_d = lvl1 & ~lvl0;
            end
            CONFLICT: conflict_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.b0        = b0_q;
    assign bus.b1        = b1_q;
    assign bus.conflict  = conflict_c;
    assign bus.state_dbg = state_q;

`ifdef BUTTON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic          armed_q;
    logic          armed_d;
    logic          clr_q;
    logic          clr_d;

    // A strobe being issued this cycle takes priority over an expiring timeout.
    always_comb begin
        tcnt_d  = tcnt_q;
        armed_d = armed_q;
        clr_d   = 1'b0;
        if (b0_d || b1_d) begin
            tcnt_d  = '0;
            armed_d = 1'b1;
        end else if (armed_q && state_q == IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tcnt_d  = '0;
                armed_d = 1'b0;
                clr_d   = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q  <= '0;
            armed_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            armed_q <= armed_d;
            clr_q   <= clr_d;
        end
    end

    assign bus.seq_clear = clr_q;
`else
    assign bus.seq_clear = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: strobes are scored against an expected queue.
// Build with +define+BUTTON_TIMEOUT_EN to also score seq_clear timing.
module tb_button_conditioner;
    import lock_pkg::*;

    localparam int LAT = 7;
    localparam int TMO = 20;
    localparam int REL = 7;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          tb_armed = 1'b0;

    logic [33:0] exp_q[$];
    logic [31:0] clr_q[$];

    button_conditioner_if bus ();

    button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // drivers: called at a negedge; the next posedge is the first to sample the change
    task automatic press(input int key);
        if (key == 0) begin
            bus.btn0_raw = 1'b1;
            exp_q.push_back({32'(cyc + LAT), 2'b01});
        end else begin
            bus.btn1_raw = 1'b1;
            exp_q.push_back({32'(cyc + LAT), 2'b10});
        end
        tb_armed = 1'b1;
    endtask

    task automatic release_key(input int key);
        if (key == 0) bus.btn0_raw = 1'b0;
        else          bus.btn1_raw = 1'b0;
    endtask

    task automatic settle();
`ifdef BUTTON_TIMEOUT_EN
        if (tb_armed) clr_q.push_back(32'(cyc + REL + TMO));
`endif
        tb_armed = 1'b0;
        tick(40);
        check_eq("settle_state", 64'(bus.state_dbg), 64'(IDLE));
        check_eq("settle_conflict", 64'(bus.conflict), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_b0", 64'(bus.b0), 64'(0));
        check_eq("rst_b1", 64'(bus.b1), 64'(0));
        check_eq("rst_conflict", 64'(bus.conflict), 64'(0));
        check_eq("rst_seq_clear", 64'(bus.seq_clear), 64'(0));
        check_eq("rst_state", 64'(bus.state_dbg), 64'(IDLE));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.b0 || bus.b1) begin
                if (exp_q.size() == 0)
                    check_eq("strobe_unexpected", 64'({cyc, bus.b1, bus.b0}), 64'(0));
                else
                    check_eq("strobe", 64'({cyc, bus.b1, bus.b0}), 64'(exp_q.pop_front()));
            end
            if (bus.seq_clear) begin
                if (clr_q.size() == 0)
                    check_eq("seq_clear_unexpected", 64'(cyc), 64'(0));
                else
                    check_eq("seq_clear", 64'(cyc), 64'(clr_q.pop_front()));
            end
        end
    end

    initial begin
        int keys[5];
        keys = '{0, 1, 0, 1, 1};
        reset        = 1'b0;
        bus.btn0_raw = 1'b0;
        bus.btn1_raw = 1'b0;
        tick(3);
        check_reset_outputs();
        reset = 1'b1;
        // idle from reset: nothing may fire, including seq_clear
        tick(60);
        check_eq("idle_state", 64'(bus.state_dbg), 64'(IDLE));

        // press, then reset while still held: re-debounced, one fresh strobe
        press(0);
        tick(12);
        check_eq("held_state", 64'(bus.state_dbg), 64'(HELD));
        reset    = 1'b0;
        tb_armed = 1'b0;
        tick(3);
        check_reset_outputs();
        reset = 1'b1;
        exp_q.push_back({32'(cyc + LAT), 2'b01});
        tb_armed = 1'b1;
        tick(30);
        release_key(0);
        settle();

        // bouncing "1" key
        bus.btn1_raw = 1'b1; tick(1);
        bus.btn1_raw = 1'b0; tick(1);
        bus.btn1_raw = 1'b1; tick(1);
        bus.btn1_raw = 1'b0; tick(1);
        press(1);
        tick(20);
        release_key(1);
        settle();

        // 3-cycle glitch is filtered
        bus.btn0_raw = 1'b1;
        tick(3);
        bus.btn0_raw = 1'b0;
        tick(20);
        check_eq("glitch_state", 64'(bus.state_dbg), 64'(IDLE));
        settle();

        // press/release sequence 0,1,0,1,1
        foreach (keys[i]) begin
            press(keys[i]);
            tick(10);
            release_key(keys[i]);
            if (i < 4) tick(10);
        end
        settle();

        // both keys together
        bus.btn0_raw = 1'b1;
        bus.btn1_raw = 1'b1;
        tick(6);
        check_eq("conflict_pre", 64'(bus.conflict), 64'(0));
        tick(1);
        check_eq("conflict_on", 64'(bus.conflict), 64'(1));
        check_eq("conflict_state", 64'(bus.state_dbg), 64'(CONFLICT));
        tick(10);
        bus.btn0_raw = 1'b0;
        tick(15);
        check_eq("conflict_one_held", 64'(bus.conflict), 64'(1));
        bus.btn1_raw = 1'b0;
        tick(5);
        check_eq("conflict_release_pre", 64'(bus.conflict), 64'(1));
        tick(2);
        check_eq("conflict_release", 64'(bus.conflict), 64'(0));
        check_eq("conflict_exit_state", 64'(bus.state_dbg), 64'(IDLE));
        settle();

        // single press then long idle: at most one seq_clear
        press(1);
        tick(10);
        release_key(1);
        settle();
        tick(60);

        check_eq("strobes_outstanding", 64'(exp_q.size()), 64'(0));
        check_eq("clears_outstanding", 64'(clr_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
